// File: rtl/morse_output_module_if.sv
// Letter request and key-line bundle for morse_output_module.
// The bench/driver side uses master; the transmitter uses slave.
interface morse_output_module_if;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] length;
  logic       morse_out;
  logic       busy;
  logic       done;

  modport master (
    output start, pattern, length,
    input  morse_out, busy, done
  );

  modport slave (
    input  start, pattern, length,
    output morse_out, busy, done
  );
endinterface

// File: rtl/morse_output_module.sv
// Morse letter transmitter: keys up to 8 dot/line symbols, LSB first, with unit gaps.
// Define MORSE_LETTER_GAP_EN to append a 3-unit low letter gap before the done pulse.
module morse_output_module #(
  parameter int UNIT_CYCLES = 4,
  parameter int LINE_UNITS  = 3
) (
  input  logic                         clock,
  input  logic                         reset,
  morse_output_module_if.slave         bus
);

  localparam logic [9:0] DOT_LOAD  = 10'(UNIT_CYCLES - 1);
  localparam logic [9:0] LINE_LOAD = 10'(LINE_UNITS * UNIT_CYCLES - 1);
`ifdef MORSE_LETTER_GAP_EN
  localparam logic [9:0] LGAP_LOAD = 10'(3 * UNIT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ON   = 3'd1,
    S_GAP  = 3'd2,
    S_DONE = 3'd3
`ifdef MORSE_LETTER_GAP_EN
    , S_LGAP = 3'd4
`endif
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] cnt_q, cnt_d;
  logic [7:0] sr_q, sr_d;
  logic [3:0] sym_q, sym_d;
  logic       morse_out_q, busy_q, done_q;

  function automatic logic [9:0] on_load(input logic is_line);
    return is_line ? LINE_LOAD : DOT_LOAD;
  endfunction

  function automatic logic [3:0] clamp_len(input logic [3:0] len);
    return (len > 4'd8) ? 4'd8 : len;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    sym_d   = sym_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.length == 4'd0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ON;
            sr_d    = bus.pattern;
            sym_d   = clamp_len(bus.length);
            cnt_d   = on_load(bus.pattern[0]);
          end
        end
      end
      S_ON: begin
        if (cnt_q != 10'd0) begin
          cnt_d = cnt_q - 10'd1;
        end else if (sym_q > 4'd1) begin
          sr_d    = {1'b0, sr_q[7:1]};
          sym_d   = sym_q - 4'd1;
          cnt_d   = DOT_LOAD;
          state_d = S_GAP;
        end else begin
`ifdef MORSE_LETTER_GAP_EN
          cnt_d   = LGAP_LOAD;
          state_d = S_LGAP;
`else
          state_d = S_DONE;
`endif
        end
      end
      S_GAP: begin
        if (cnt_q != 10'd0) begin
          cnt_d = cnt_q - 10'd1;
        end else begin
          cnt_d   = on_load(sr_q[0]);
          state_d = S_ON;
        end
      end
`ifdef MORSE_LETTER_GAP_EN
      S_LGAP: begin
        if (cnt_q != 10'd0) cnt_d = cnt_q - 10'd1;
        else                state_d = S_DONE;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 10'd0;
      sr_q        <= 8'd0;
      sym_q       <= 4'd0;
      morse_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      sym_q       <= sym_d;
      morse_out_q <= (state_d == S_ON);
      busy_q      <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_q      <= (state_d == S_DONE);
    end
  end

  assign bus.morse_out = morse_out_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_morse_output_module.sv
// Bench for morse_output_module: per-cycle queue model of the expected key waveform,
// literal waveform checks for the worked examples, then randomized traffic.
module tb_morse_output_module;
  localparam int U = 2;
  localparam int L = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  morse_output_module_if bus();

  morse_output_module #(.UNIT_CYCLES(U), .LINE_UNITS(L)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: on acceptance, the whole letter is expanded into a queue of {morse,busy,done}
  logic [2:0] q[$];
  logic [2:0] exp_v = 3'b000;
  bit         chk_en = 1'b0;

  task automatic build(input logic [7:0] pat, input logic [3:0] len);
    int n;
    n = (len > 4'd8) ? 8 : int'(len);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < (pat[i] ? L * U : U); c++) q.push_back(3'b110);
      if (i < n - 1)
        for (int c = 0; c < U; c++) q.push_back(3'b010);
    end
`ifdef MORSE_LETTER_GAP_EN
    if (n > 0)
      for (int c = 0; c < 3 * U; c++) q.push_back(3'b010);
`endif
    q.push_back(3'b001);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      exp_v  <= 3'b000;
      chk_en <= 1'b1;
    end else begin
      if (q.size() == 0 && !exp_v[0] && bus.start) build(bus.pattern, bus.length);
      if (q.size() > 0) exp_v <= q.pop_front();
      else              exp_v <= 3'b000;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks += 3;
      if (bus.morse_out !== exp_v[2]) begin
        errors++;
        $display("FAIL model_morse t=%0t got %b expected %b", $time, bus.morse_out, exp_v[2]);
      end
      if (bus.busy !== exp_v[1]) begin
        errors++;
        $display("FAIL model_busy t=%0t got %b expected %b", $time, bus.busy, exp_v[1]);
      end
      if (bus.done !== exp_v[0]) begin
        errors++;
        $display("FAIL model_done t=%0t got %b expected %b", $time, bus.done, exp_v[0]);
      end
    end
  end

  // Capture buffers: bit k-1 holds cycle k after the start edge
  logic [95:0] cm, cb, cd;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [95:0] got, input logic [95:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, req);
    end
  endtask

  task automatic launch(input logic [7:0] pat, input logic [3:0] len);
    tick();
    bus.start = 1'b1; bus.pattern = pat; bus.length = len;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic capture(input int n);
    cm = '0; cb = '0; cd = '0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      cm[k-1] = bus.morse_out; cb[k-1] = bus.busy; cd[k-1] = bus.done;
    end
  endtask

`ifdef MORSE_LETTER_GAP_EN
  localparam logic [95:0] B32 = 96'h0F_FFFF;
  localparam logic [95:0] D32 = 96'h10_0000;
  localparam int          D34 = 69;
  localparam logic [95:0] B36 = 96'h3FFF_FC3F;
  localparam logic [95:0] D36 = 96'h4000_0000;
`else
  localparam logic [95:0] B32 = 96'h00_3FFF;
  localparam logic [95:0] D32 = 96'h00_4000;
  localparam int          D34 = 63;
  localparam logic [95:0] B36 = 96'h00FF_FC3F;
  localparam logic [95:0] D36 = 96'h0100_0000;
`endif
  localparam logic [95:0] M32 = 96'h33F3;
  localparam logic [95:0] M36 = 96'hCF_CC33;

  initial begin
    int highs, rises, done_at, dones;
    logic prev;
    bus.start = 1'b0; bus.pattern = 8'h00; bus.length = 4'd0;
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("reset_state", {93'd0, bus.morse_out, bus.busy, bus.done}, 96'd0);
    tick();
    rst = 1'b0;
    repeat (3) tick();

    // Worked example: dot, line, dot
    launch(8'b010, 4'd3);
    capture(24);
    check("ex_morse", cm & 96'hFF_FFFF, M32);
    check("ex_busy",  cb & 96'hFF_FFFF, B32);
    check("ex_done",  cd & 96'hFF_FFFF, D32);

    // Zero length: immediate done, no keying
    launch(8'hFF, 4'd0);
    capture(4);
    check("len0_morse", cm & 96'hF, 96'h0);
    check("len0_busy",  cb & 96'hF, 96'h0);
    check("len0_done",  cd & 96'hF, 96'h1);

    // Clamped length: eight lines
    launch(8'hFF, 4'd12);
    capture(80);
    highs = 0; rises = 0; done_at = 0; prev = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      if (cm[k-1]) highs++;
      if (cm[k-1] && !prev) rises++;
      if (cd[k-1]) done_at = k;
      prev = cm[k-1];
    end
    check("clamp_high_cycles", 96'(highs), 96'(8 * L * U));
    check("clamp_lines",       96'(rises), 96'd8);
    check("clamp_done_cycle",  96'(done_at), 96'(D34));

    // Reset mid-letter, then a fresh start
    tick();
    bus.start = 1'b1; bus.pattern = 8'b010; bus.length = 4'd3;
    tick();
    bus.start = 1'b0;
    cm = '0; cb = '0; cd = '0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      cm[k-1] = bus.morse_out; cb[k-1] = bus.busy; cd[k-1] = bus.done;
      if (k == 6)  rst = 1'b1;
      if (k == 7)  rst = 1'b0;
      if (k == 10) begin bus.start = 1'b1; bus.pattern = 8'b010; bus.length = 4'd3; end
      if (k == 11) bus.start = 1'b0;
    end
    check("abort_morse", cm & 96'hFFFF_FFFF, M36);
    check("abort_busy",  cb & 96'hFFFF_FFFF, B36);
    check("abort_done",  cd & 96'hFFFF_FFFF, D36);

    // Input changes and start pulses while busy are ignored
    tick();
    bus.start = 1'b1; bus.pattern = 8'b010; bus.length = 4'd3;
    tick();
    bus.start = 1'b0;
    cm = '0; cb = '0; cd = '0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      cm[k-1] = bus.morse_out; cb[k-1] = bus.busy; cd[k-1] = bus.done;
      if (k == 3) begin bus.start = 1'b1; bus.pattern = 8'hFF; bus.length = 4'd8; end
      if (k == 4) bus.start = 1'b0;
      if (k == 8) begin bus.start = 1'b1; bus.pattern = 8'h00; bus.length = 4'd15; end
      if (k == 9) bus.start = 1'b0;
    end
    dones = 0;
    for (int k = 0; k < 24; k++) if (cd[k]) dones++;
    check("busy_ignore_morse", cm & 96'hFF_FFFF, M32);
    check("busy_ignore_dones", 96'(dones), 96'd1);

    // Randomized traffic, including occasional resets and start held across reset release
    for (int i = 0; i < 4000; i++) begin
      tick();
      bus.start   = ($urandom_range(0, 3) == 0);
      bus.pattern = 8'($urandom);
      bus.length  = 4'($urandom_range(0, 15));
      rst         = ($urandom_range(0, 149) == 0);
    end
    tick();
    rst = 1'b0; bus.start = 1'b0;
    repeat (120) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
